// File: rtl/axi_adf4030_trig_sched.sv
`default_nettype none
//==============================================================================
// Module : axi_adf4030_trig_sched
// Desc   : Waits for a BSYNC period start after a trigger request, then pulses
//          each enabled channel at its latched phase offset within the period.
// Option : ADF4030_TRIG_REPEAT_EN adds repeat_cnt for multi-period runs.
// Rev    : 1.0
//==============================================================================
module axi_adf4030_trig_sched #(
  parameter int CHANNEL_COUNT = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        trig_req,
  input  logic                        trig_abort,
  input  logic                        bsync_edge,
  input  logic [15:0]                 bsync_ratio,
  input  logic [CHANNEL_COUNT-1:0]    channel_en,
  input  logic [16*CHANNEL_COUNT-1:0] channel_phase,
`ifdef ADF4030_TRIG_REPEAT_EN
  input  logic [7:0]                  repeat_cnt,
`endif
  output logic                        trig_ack,
  output logic                        trig_rej,
  output logic                        busy,
  output logic                        done,
  output logic [CHANNEL_COUNT-1:0]    trig_out,
  output logic [CHANNEL_COUNT-1:0]    phase_err,
  output logic [2:0]                  state
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_ARM  = 3'd1;
  localparam logic [2:0] c_RUN  = 3'd2;
  localparam logic [2:0] c_DONE = 3'd3;

  logic [2:0]                  r_state;
  logic [15:0]                 r_cnt;
  logic [CHANNEL_COUNT-1:0]    r_en_lat;
  logic [16*CHANNEL_COUNT-1:0] r_phase_lat;
  logic [15:0]                 r_ratio_lat;
  logic                        r_trig_ack;
  logic                        r_trig_rej;
  logic                        r_done;
  logic [CHANNEL_COUNT-1:0]    r_trig_out;
  logic [CHANNEL_COUNT-1:0]    r_phase_err;

  logic [2:0]                  w_state_nxt;
  logic [15:0]                 w_cnt_nxt;
  logic                        w_req_seen;
  logic                        w_req_valid;
  logic                        w_accept;
  logic                        w_period_end;
  logic                        w_last_period;
  logic [CHANNEL_COUNT-1:0]    w_fire;
  logic [CHANNEL_COUNT-1:0]    w_perr_new;

  assign w_req_seen   = (r_state == c_IDLE) && trig_req;
  assign w_req_valid  = (bsync_ratio >= 16'd2) && (|channel_en);
  assign w_accept     = w_req_seen && w_req_valid;
  assign w_period_end = (r_cnt == (r_ratio_lat - 16'd1));

`ifdef ADF4030_TRIG_REPEAT_EN
  logic [7:0] r_rep_left;

  assign w_last_period = (r_rep_left == 8'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rep_left <= 8'd0;
    end else if (w_accept) begin
      r_rep_left <= repeat_cnt;
    end else if ((r_state == c_RUN) && (w_state_nxt == c_ARM)) begin
      r_rep_left <= r_rep_left - 8'd1;
    end
  end
`else
  assign w_last_period = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_state == c_RUN) ? (r_cnt + 16'd1) : 16'd0;
    case (r_state)
      c_IDLE: if (w_accept) w_state_nxt = c_ARM;
      c_ARM:  if (bsync_edge) w_state_nxt = c_RUN;
      c_RUN:  if (w_period_end) w_state_nxt = w_last_period ? c_DONE : c_ARM;
      c_DONE: w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
    // Abort outranks every other transition, including the period end.
    if (trig_abort && (r_state != c_IDLE)) begin
      w_state_nxt = c_IDLE;
    end
  end

  // Fire decisions look at the next count so trig_out lands exactly on cnt==phase.
  generate
    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
      assign w_fire[i] = r_en_lat[i]
                       && (r_phase_lat[16*i +: 16] == w_cnt_nxt)
                       && (r_phase_lat[16*i +: 16] < r_ratio_lat);
      assign w_perr_new[i] = channel_en[i] && (channel_phase[16*i +: 16] >= bsync_ratio);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= c_IDLE;
      r_cnt       <= 16'd0;
      r_en_lat    <= '0;
      r_phase_lat <= '0;
      r_ratio_lat <= 16'd0;
      r_trig_ack  <= 1'b0;
      r_trig_rej  <= 1'b0;
      r_done      <= 1'b0;
      r_trig_out  <= '0;
      r_phase_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_trig_ack <= w_req_seen;
      r_trig_rej <= w_req_seen && !w_req_valid;
      r_done     <= (w_state_nxt == c_DONE);
      r_trig_out <= (w_state_nxt == c_RUN) ? w_fire : '0;
      if (w_accept) begin
        r_en_lat    <= channel_en;
        r_phase_lat <= channel_phase;
        r_ratio_lat <= bsync_ratio;
        r_phase_err <= w_perr_new;
      end
    end
  end

  assign trig_ack  = r_trig_ack;
  assign trig_rej  = r_trig_rej;
  assign busy      = (r_state != c_IDLE);
  assign done      = r_done;
  assign trig_out  = r_trig_out;
  assign phase_err = r_phase_err;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_axi_adf4030_trig_sched.sv
`default_nettype none
//==============================================================================
// Module : tb_axi_adf4030_trig_sched
// Desc   : Directed and randomized runs of the trigger scheduler, checked
//          against a period/offset model of expected pulses.
// Rev    : 1.0
//==============================================================================
module tb_axi_adf4030_trig_sched;

  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            trig_req;
  logic            trig_abort;
  logic            bsync_edge;
  logic [15:0]     bsync_ratio;
  logic [CH-1:0]   channel_en;
  logic [16*CH-1:0] channel_phase;
  logic [7:0]      repeat_cnt;
  logic            trig_ack;
  logic            trig_rej;
  logic            busy;
  logic            done;
  logic [CH-1:0]   trig_out;
  logic [CH-1:0]   phase_err;
  logic [2:0]      state;

  int total = 0;
  int bad   = 0;

  // Model copies of what the block should have latched
  logic [CH-1:0] m_en;
  logic [15:0]   m_ph [CH];
  logic [15:0]   m_ratio;
  int            m_rep;
  logic [CH-1:0] m_perr;

  always #5 clk = ~clk;

  axi_adf4030_trig_sched #(.CHANNEL_COUNT(CH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .trig_req      (trig_req),
    .trig_abort    (trig_abort),
    .bsync_edge    (bsync_edge),
    .bsync_ratio   (bsync_ratio),
    .channel_en    (channel_en),
    .channel_phase (channel_phase),
`ifdef ADF4030_TRIG_REPEAT_EN
    .repeat_cnt    (repeat_cnt),
`endif
    .trig_ack      (trig_ack),
    .trig_rej      (trig_rej),
    .busy          (busy),
    .done          (done),
    .trig_out      (trig_out),
    .phase_err     (phase_err),
    .state         (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] exp_trig(input int k);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++)
      r[i] = m_en[i] && (int'(m_ph[i]) == k) && (m_ph[i] < m_ratio);
    return r;
  endfunction

  task automatic scramble();
    channel_en    = CH'($urandom);
    channel_phase = {$urandom, $urandom};
    bsync_ratio   = 16'($urandom);
    repeat_cnt    = 8'($urandom);
  endtask

  task automatic start_run(input logic [CH-1:0] en, input logic [16*CH-1:0] ph,
                           input logic [15:0] ratio, input int rep);
    channel_en    = en;
    channel_phase = ph;
    bsync_ratio   = ratio;
    repeat_cnt    = 8'(rep);
    trig_req      = 1'b1;
    tick();
    trig_req = 1'b0;
    m_en    = en;
    m_ratio = ratio;
`ifdef ADF4030_TRIG_REPEAT_EN
    m_rep = rep;
`else
    m_rep = 0;
`endif
    for (int i = 0; i < CH; i++) begin
      m_ph[i]   = ph[16*i +: 16];
      m_perr[i] = en[i] && (m_ph[i] >= ratio);
    end
    chk("ack_valid", {31'd0, trig_ack}, 32'd1);
    chk("rej_valid", {31'd0, trig_rej}, 32'd0);
    chk("state_arm", {29'd0, state}, 32'd1);
    chk("perr_accept", {28'd0, phase_err}, {28'd0, m_perr});
    scramble();
  endtask

  task automatic post_abort_checks();
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_trig", {28'd0, trig_out}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_perr", {28'd0, phase_err}, {28'd0, m_perr});
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("post_abort_quiet", {28'd0, trig_out, done, busy}, 32'd0);
    end
  endtask

  // One BSYNC period: gap cycles in ARM, optional abort, then the pulse train.
  task automatic run_period(input int gap, input bit last, input bit abort_arm,
                            input int abort_k, output bit aborted);
    aborted = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bsync_edge = 1'b0;
      trig_req   = 1'($urandom);
      tick();
      chk("arm_wait", {27'd0, state, trig_out, trig_ack}, {27'd0, 3'd1, 4'd0, 1'b0});
    end
    trig_req = 1'b0;
    if (abort_arm) begin
      trig_abort = 1'b1;
      bsync_edge = 1'($urandom);
      tick();
      trig_abort = 1'b0;
      bsync_edge = 1'b0;
      post_abort_checks();
      aborted = 1'b1;
      return;
    end
    bsync_edge = 1'b1;
    tick();
    for (int k = 0; k < int'(m_ratio); k++) begin
      chk("run_state", {29'd0, state}, 32'd2);
      chk("run_trig", {28'd0, trig_out}, {28'd0, exp_trig(k)});
      chk("run_misc", {29'd0, done, trig_ack, busy}, 32'd1);
      if (k == abort_k) begin
        trig_abort = 1'b1;
        tick();
        trig_abort = 1'b0;
        post_abort_checks();
        aborted = 1'b1;
        return;
      end
      bsync_edge = (k < int'(m_ratio) - 1) ? 1'($urandom) : 1'b0;
      trig_req   = (k < int'(m_ratio) - 1) ? 1'($urandom) : 1'b0;
      scramble();
      tick();
    end
    bsync_edge = 1'b0;
    chk("end_trig", {28'd0, trig_out}, 32'd0);
    if (last) begin
      chk("done_state", {29'd0, state}, 32'd3);
      chk("done_pulse", {30'd0, done, busy}, 32'd3);
      tick();
      chk("idle_after", {26'd0, state, done, busy, trig_ack}, 32'd0);
      chk("perr_kept", {28'd0, phase_err}, {28'd0, m_perr});
    end else begin
      chk("rearm_state", {29'd0, state}, 32'd1);
      chk("rearm_done", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic full_run(input logic [CH-1:0] en, input logic [16*CH-1:0] ph,
                          input logic [15:0] ratio, input int rep, input int mode);
    bit ab;
    int p_ab;
    start_run(en, ph, ratio, rep);
    p_ab = $urandom_range(0, m_rep);
    for (int p = 0; p <= m_rep; p++) begin
      run_period($urandom_range(0, 3), p == m_rep,
                 (mode == 1) && (p == p_ab),
                 ((mode == 2) && (p == p_ab)) ? $urandom_range(0, int'(m_ratio) - 1) : -1,
                 ab);
      if (ab) break;
    end
  endtask

  task automatic bad_req(input logic [CH-1:0] en, input logic [15:0] ratio);
    channel_en    = en;
    bsync_ratio   = ratio;
    channel_phase = {$urandom, $urandom};
    trig_req      = 1'b1;
    tick();
    trig_req = 1'b0;
    chk("rej_pulse", {29'd0, trig_ack, trig_rej, busy}, 32'd6);
    chk("rej_state", {29'd0, state}, 32'd0);
    chk("rej_perr", {28'd0, phase_err}, {28'd0, m_perr});
    tick();
    chk("rej_once", {30'd0, trig_ack, trig_rej}, 32'd0);
  endtask

  initial begin
    rstn          = 1'b0;
    trig_req      = 1'b0;
    trig_abort    = 1'b0;
    bsync_edge    = 1'b0;
    bsync_ratio   = 16'd0;
    channel_en    = '0;
    channel_phase = '0;
    repeat_cnt    = 8'd0;
    m_perr        = '0;
    m_en          = '0;
    m_ratio       = 16'd0;
    m_rep         = 0;
    for (int i = 0; i < CH; i++) m_ph[i] = 16'd0;

    // Reset holds everything at zero whatever the inputs do
    for (int j = 0; j < 6; j++) begin
      trig_req   = 1'($urandom);
      trig_abort = 1'($urandom);
      bsync_edge = 1'($urandom);
      scramble();
      tick();
      chk("reset_outs", {17'd0, trig_ack, trig_rej, busy, done, trig_out, phase_err, state}, 32'd0);
    end
    trig_req   = 1'b0;
    trig_abort = 1'b0;
    bsync_edge = 1'b0;
    rstn       = 1'b1;
    tick();
    chk("idle_after_reset", {29'd0, state}, 32'd0);

    full_run(4'b1011, {16'd9, 16'd5, 16'd3, 16'd0}, 16'd10, 0, 0);
    full_run(4'b0001, {16'd0, 16'd0, 16'd0, 16'd8}, 16'd8, 0, 0);

    bad_req(4'b1111, 16'd1);
    bad_req(4'b0000, 16'd10);
    bad_req(4'b0101, 16'd0);

    // Abort in RUN at cnt==2, then in ARM
    start_run(4'b1111, {16'd5, 16'd3, 16'd2, 16'd1}, 16'd8, 0);
    begin
      bit ab;
      run_period(1, 1'b1, 1'b0, 2, ab);
    end
    start_run(4'b0011, {16'd0, 16'd0, 16'd1, 16'd0}, 16'd4, 0);
    begin
      bit ab;
      run_period(2, 1'b1, 1'b1, -1, ab);
    end

`ifdef ADF4030_TRIG_REPEAT_EN
    full_run(4'b0011, {16'd0, 16'd0, 16'd3, 16'd1}, 16'd4, 2, 0);
`endif

    for (int r = 0; r < 25; r++) begin
      logic [16*CH-1:0] ph;
      for (int i = 0; i < CH; i++) ph[16*i +: 16] = 16'($urandom_range(0, 13));
      full_run(CH'($urandom_range(1, 15)), ph, 16'($urandom_range(2, 12)),
               $urandom_range(0, 2), $urandom_range(0, 5));
      if ((r % 5) == 4) bad_req(CH'($urandom_range(0, 15)), 16'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run abandons it and clears phase_err
    start_run(4'b1000, {16'd20, 16'd0, 16'd0, 16'd0}, 16'd12, 0);
    bsync_edge = 1'b1;
    tick();
    bsync_edge = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    chk("midrun_reset", {17'd0, trig_ack, trig_rej, busy, done, trig_out, phase_err, state}, 32'd0);
    rstn = 1'b1;
    m_perr = '0;
    for (int j = 0; j < 14; j++) begin
      tick();
      chk("after_reset_quiet", {25'd0, state, done, busy, trig_out[0]}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
